if_prefetch: RTL and testbench

Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue between the instruction ROM port and decode. It runs ahead of decode, issuing sequential fetches through the ROM request/busy/done handshake. Each returned word is queued with its PC, and queued words are presented to decode with a valid/stall handshake. A redirect (branch/jump) flushes the queue, discards any in-flight return, and restarts fetch at the new PC.

---
 rtl/if_prefetch_if.sv | 29 ++
 rtl/if_prefetch.sv | 125 ++++++++++++
 tb/tb_if_prefetch.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_if.sv
// Fetch-stage bundle: ROM request/return port, decode-side queue head, and redirect.
// master = prefetch stage, slave = surrounding ROM/decode environment.
interface if_prefetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              flush_i;
    logic [ADDR_W-1:0] flush_pc_i;
    logic              stall_i;
    logic [ADDR_W-1:0] rom_addr_o;
    logic              r_enable_o;
    logic              rom_busy_i;
    logic              rom_done_i;
    logic [INST_W-1:0] rom_data_i;
    logic [ADDR_W-1:0] pc_o;
    logic [INST_W-1:0] inst_o;
    logic              valid_o;
    logic              stall_req_o;

    modport master (
        input  flush_i, flush_pc_i, stall_i, rom_busy_i, rom_done_i, rom_data_i,
        output rom_addr_o, r_enable_o, pc_o, inst_o, valid_o, stall_req_o
    );

    modport slave (
        output flush_i, flush_pc_i, stall_i, rom_busy_i, rom_done_i, rom_data_i,
        input  rom_addr_o, r_enable_o, pc_o, inst_o, valid_o, stall_req_o
    );
endinterface

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: runs sequential ROM fetches ahead of decode into a DEPTH-entry
// queue of {pc, inst}; a redirect flushes the queue and drops any in-flight return.
module if_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    if_prefetch_if.master bus
);
    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INST_W / 8);
    localparam logic [CNT_W-1:0]  FULL    = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic              push;
    logic              pop;
    logic              valid;

    assign valid = (count_q != '0);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;
        pop        = valid && !bus.stall_i;

        case (state_q)
            IDLE: begin
                if (count_q < FULL && !bus.flush_i) begin
                    req_pc_d = fetch_pc_q;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (!bus.rom_busy_i) state_d = WAIT;
            end
            WAIT: begin
                if (bus.rom_done_i) begin
                    push       = 1'b1;
                    fetch_pc_d = req_pc_q + PC_STEP;
                    state_d    = IDLE;
                end
            end
            DISCARD: begin
                if (bus.rom_done_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A redirect wins over queue traffic; an accepted request still owes one return to drop.
        if (bus.flush_i) begin
            push       = 1'b0;
            pop        = 1'b0;
            fetch_pc_d = bus.flush_pc_i;
            case (state_q)
                REQ:           state_d = bus.rom_busy_i ? IDLE : DISCARD;
                WAIT, DISCARD: state_d = bus.rom_done_i ? IDLE : DISCARD;
                default:       state_d = IDLE;
            endcase
        end

        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (bus.flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // NOTE: queue storage is reset on purpose so pc_o/inst_o read zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
            inst_mem_q[wr_ptr_q] <= bus.rom_data_i;
        end
    end

    assign bus.r_enable_o  = (state_q == REQ);
    assign bus.rom_addr_o  = req_pc_q;
    assign bus.valid_o     = valid;
    assign bus.stall_req_o = ~valid;
    assign bus.pc_o        = pc_mem_q[rd_ptr_q];
    assign bus.inst_o      = inst_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed scenarios then randomized ROM/decode traffic, all checked
// against a queue-level model of the fetch stream (ROM responder side plus an SV queue).
module tb_if_prefetch;
    localparam int          ADDR_W   = 32;
    localparam int          INST_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_prefetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    if_prefetch #(
        .ADDR_W  (ADDR_W),
        .INST_W  (INST_W),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    entry_t      q[$];
    logic [31:0] exp_fetch;
    logic [31:0] out_addr;
    bit          outstanding;
    bit          discard;
    int          done_cnt;
    int          gap;
    int          req_len;
    int          last_req_len;
    int          cyc;
    int          first_valid_cyc;
    logic [31:0] acc_log[$];
    int          ren_rise_cyc[$];

    int          stall_pct, busy_pct, busy_left, done_min, done_max;
    bit          spurious_done;
    bit          flush_now;
    logic [31:0] flush_target;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        q.delete();
        acc_log.delete();
        ren_rise_cyc.delete();
        exp_fetch       = RESET_PC;
        outstanding     = 1'b0;
        discard         = 1'b0;
        done_cnt        = 0;
        gap             = 0;
        req_len         = 0;
        busy_left       = 0;
        cyc             = 0;
        first_valid_cyc = -1;
    endtask

    // Called at a falling edge; asserts reset, checks reset outputs, releases on a later falling edge.
    task automatic do_reset();
        bus.flush_i    = 1'b0;
        bus.flush_pc_i = '0;
        bus.stall_i    = 1'b0;
        bus.rom_busy_i = 1'b0;
        bus.rom_done_i = 1'b0;
        bus.rom_data_i = '0;
        rst = 1'b0;
        #1;
        check("rst_r_enable", bus.r_enable_o, 1'b0);
        check("rst_rom_addr", bus.rom_addr_o, RESET_PC);
        check("rst_valid", bus.valid_o, 1'b0);
        check("rst_stall_req", bus.stall_req_o, 1'b1);
        check("rst_pc", bus.pc_o, 32'h0);
        check("rst_inst", bus.inst_o, 32'h0);
        reset_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock: sample/check at the falling edge, drive inputs, advance the model, wait one period.
    task automatic cycle();
        logic ren;
        logic [31:0] raddr;
        logic stall, busy, done;
        logic accept, deliver, pop_now;
        entry_t e;

        ren   = bus.r_enable_o;
        raddr = bus.rom_addr_o;
        check("valid", bus.valid_o, q.size() != 0);
        check("stall_req", bus.stall_req_o, q.size() == 0);
        if (q.size() != 0) begin
            check("head_pc", bus.pc_o, q[0].pc);
            check("head_inst", bus.inst_o, q[0].inst);
        end
        if (bus.valid_o === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (ren === 1'b1) begin
            check("req_addr", raddr, exp_fetch);
            check("req_legal", {outstanding, q.size() < DEPTH}, 2'b01);
            if (req_len == 0) ren_rise_cyc.push_back(cyc);
            req_len++;
        end
        if (ren !== 1'b1 && !outstanding && q.size() < DEPTH) gap++;
        else gap = 0;
        check("issue_gap", gap <= 1, 1'b1);

        stall = ($urandom_range(99) < stall_pct);
        busy  = (busy_left > 0) ? 1'b1 : ($urandom_range(99) < busy_pct);
        if (ren === 1'b1 && busy_left > 0) busy_left--;
        done = 1'b0;
        if (outstanding) begin
            if (done_cnt == 0) done = 1'b1;
            else done_cnt--;
        end else if (spurious_done) begin
            done = 1'b1;
        end
        bus.flush_i    = flush_now;
        bus.flush_pc_i = flush_target;
        bus.stall_i    = stall;
        bus.rom_busy_i = busy;
        bus.rom_done_i = done;
        bus.rom_data_i = (done && outstanding) ? rom_word(out_addr) : $urandom();

        accept  = (ren === 1'b1) && !busy;
        deliver = outstanding && done;
        pop_now = !flush_now && q.size() != 0 && !stall;
        if (pop_now) void'(q.pop_front());
        if (deliver) begin
            outstanding = 1'b0;
            if (!discard && !flush_now) begin
                e.pc   = out_addr;
                e.inst = rom_word(out_addr);
                q.push_back(e);
                exp_fetch = out_addr + 32'd4;
            end
            discard = 1'b0;
        end
        if (accept) begin
            outstanding  = 1'b1;
            out_addr     = raddr;
            done_cnt     = $urandom_range(done_max, done_min);
            acc_log.push_back(raddr);
            last_req_len = req_len;
            req_len      = 0;
        end
        if (flush_now) begin
            q.delete();
            exp_fetch = flush_target;
            if (outstanding) discard = 1'b1;
            if (ren === 1'b1 && busy) req_len = 0;
            gap = 0;
        end
        flush_now = 1'b0;

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int n;
        int a0;
        stall_pct     = 0;
        busy_pct      = 0;
        busy_left     = 0;
        done_min      = 0;
        done_max      = 0;
        spurious_done = 1'b0;
        flush_now     = 1'b0;
        flush_target  = '0;
        @(negedge clk);

        // Free-running fetch, done one cycle after accept, no stall.
        do_reset();
        repeat (14) cycle();
        check("first_req_cycle", ren_rise_cyc.size() > 0 ? ren_rise_cyc[0] : -1, 1);
        check("first_valid_cycle", first_valid_cyc, 3);
        check("second_req_cycle", ren_rise_cyc.size() > 1 ? ren_rise_cyc[1] : -1, 4);
        check("seq_count", acc_log.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) check("seq_addr", acc_log[i], 32'(4 * i));

        // Decode stalled: queue fills, then drains on consecutive edges.
        do_reset();
        stall_pct = 100;
        repeat (25) cycle();
        check("fill_requests", acc_log.size(), DEPTH);
        check("fill_no_5th_req", bus.r_enable_o, 1'b0);
        check("fill_valid", bus.valid_o, 1'b1);
        stall_pct = 0;
        a0 = acc_log.size();
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", bus.valid_o, 1'b1);
            check("drain_pc", bus.pc_o, 32'(4 * i));
            cycle();
        end
        n = 0;
        while (acc_log.size() == a0 && n < 20) begin cycle(); n++; end
        check("resume_timeout", n < 20, 1'b1);
        check("resume_addr", acc_log.size() > a0 ? acc_log[a0] : 32'hDEAD, 32'h10);

        // Three busy cycles on one request.
        n = 0;
        while ((outstanding || bus.r_enable_o === 1'b1) && n < 20) begin cycle(); n++; end
        busy_left = 3;
        a0 = acc_log.size();
        n = 0;
        while (acc_log.size() == a0 && n < 20) begin cycle(); n++; end
        check("busy_timeout", n < 20, 1'b1);
        check("busy_req_len", last_req_len, 4);

        // Redirect while the return is still outstanding.
        done_min = 3;
        done_max = 3;
        n = 0;
        while (!(outstanding && done_cnt >= 2) && n < 30) begin cycle(); n++; end
        check("wait_timeout", n < 30, 1'b1);
        flush_now    = 1'b1;
        flush_target = 32'h200;
        a0 = acc_log.size();
        cycle();
        check("flush_valid_next", bus.valid_o, 1'b0);
        n = 0;
        while (bus.valid_o !== 1'b1 && n < 40) begin cycle(); n++; end
        check("flush_refill_timeout", n < 40, 1'b1);
        check("flush_first_addr", acc_log.size() > a0 ? acc_log[a0] : 32'hDEAD, 32'h200);
        check("flush_head_pc", bus.pc_o, 32'h200);
        check("flush_head_inst", bus.inst_o, rom_word(32'h200));

        // Redirect coincident with a return and a pop: no discard state.
        done_min  = 1;
        done_max  = 1;
        stall_pct = 100;
        n = 0;
        while (!(outstanding && done_cnt == 0 && q.size() >= 1) && n < 60) begin cycle(); n++; end
        check("coinc_setup_timeout", n < 60, 1'b1);
        stall_pct    = 0;
        flush_now    = 1'b1;
        flush_target = 32'h300;
        cycle();
        check("coinc_valid", bus.valid_o, 1'b0);
        n = 0;
        while (bus.r_enable_o !== 1'b1 && n < 10) begin cycle(); n++; end
        check("coinc_req_delay", n, 1);
        check("coinc_req_addr", bus.rom_addr_o, 32'h300);

        // Reset mid-request with two entries queued; stray done right after release.
        stall_pct = 100;
        done_min  = 2;
        done_max  = 2;
        n = 0;
        while (!(q.size() == 2 && outstanding) && n < 60) begin cycle(); n++; end
        check("mid_rst_setup_timeout", n < 60, 1'b1);
        do_reset();
        stall_pct     = 0;
        done_min      = 0;
        done_max      = 0;
        spurious_done = 1'b1;
        cycle();
        spurious_done = 1'b0;
        n = 0;
        while (acc_log.size() == 0 && n < 10) begin cycle(); n++; end
        check("post_rst_addr", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD, RESET_PC);
        check("post_rst_req_cycle", ren_rise_cyc.size() > 0 ? ren_rise_cyc[0] : -1, 1);

        // Random traffic, including redirects near the top of the address space.
        stall_pct = 30;
        busy_pct  = 30;
        done_min  = 0;
        done_max  = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 4) begin
                flush_now    = 1'b1;
                flush_target = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & ~32'h3);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
